// File: rtl/inst_rom_arbiter_pkg.sv
// rtl/inst_rom_arbiter_pkg.sv - shared bus macros, port ids, buffer states and defaults for inst_rom_arbiter
`ifndef INST_ROM_ARBITER_PKG_SV
`define INST_ROM_ARBITER_PKG_SV

`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef InstBus
`define InstBus 31:0
`endif

package inst_rom_arbiter_pkg;

  // Requester identity, also used as the arbitration winner code
  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

  // One-entry response buffer occupancy
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_W           = 4;

  // Saturating increment of the fetch starvation counter
  function automatic logic [STARVE_W-1:0] starve_next(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] lim
  );
    if (cnt >= lim) begin
      return lim;
    end
    return cnt + 1'b1;
  endfunction

endpackage

`endif

// File: rtl/arb_resp_buf.sv
// rtl/arb_resp_buf.sv - one-entry response holding register with load, drain and clear
module arb_resp_buf
  import inst_rom_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  buf_state_e state;

  // A reload wins over drain/clear so a back-to-back response keeps valid high
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BUF_EMPTY;
      dout  <= '0;
    end else begin
      if (load) begin
        dout <= din;
      end
      case (state)
        BUF_EMPTY: begin
          if (load) begin
            state <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (load) begin
            state <= BUF_FULL;
          end else if (clear || drain) begin
            state <= BUF_EMPTY;
          end
        end
      endcase
    end
  end

  assign valid = (state == BUF_FULL);

endmodule

// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - shares the inst_rom read port between fetch (F) and data (D); INST_ROM_ARB_PERF_EN adds perf counters
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          f_rready,
  output logic [DW-1:0] f_inst1,
  output logic [DW-1:0] f_inst2,
  output logic [AW-1:0] f_inst1_addr,
  output logic [AW-1:0] f_inst2_addr,
  input  logic          flush,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          d_rready,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst1,
  input  logic [DW-1:0] rom_inst2,
  input  logic [AW-1:0] rom_inst1_addr,
  input  logic [AW-1:0] rom_inst2_addr
`ifdef INST_ROM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_f_gnt,
  output logic [31:0]   perf_d_gnt,
  output logic [31:0]   perf_conflict
`endif
);

  localparam int                FW         = 2 * (DW + AW);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic                f_elig;
  logic                d_elig;
  logic                starve_hit;
  logic                any_elig;
  port_id_e            winner;
  logic [STARVE_W-1:0] starve_cnt;
  logic [FW-1:0]       f_din;
  logic [FW-1:0]       f_dout;

  // A port may compete only if its buffer is empty or being drained this cycle
  always_comb begin
    f_elig     = f_req && !flush && (!f_rvalid || f_rready);
    d_elig     = d_req && (!d_rvalid || d_rready);
    starve_hit = (starve_cnt == STARVE_LIM);
    any_elig   = f_elig || d_elig;
    winner     = (f_elig && (!d_elig || starve_hit)) ? PORT_F : PORT_D;
  end

  // Grants are withheld while reset is asserted
  always_comb begin
    f_gnt  = rst && any_elig && (winner == PORT_F);
    d_gnt  = rst && any_elig && (winner == PORT_D);
    rom_ce = f_gnt || d_gnt;
    if (f_gnt) begin
      rom_addr = f_addr;
    end else if (d_gnt) begin
      rom_addr = {d_addr[AW-1:2], 2'b00};
    end else begin
      rom_addr = '0;
    end
  end

  // Counts consecutive cycles where fetch was ready to go but data took the port
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (f_elig && d_gnt) begin
      starve_cnt <= starve_next(starve_cnt, STARVE_LIM);
    end else begin
      starve_cnt <= '0;
    end
  end

  assign f_din = {rom_inst1_addr, rom_inst2_addr, rom_inst1, rom_inst2};

  arb_resp_buf #(
    .W (FW)
  ) u_f_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (f_gnt),
    .drain (f_rready),
    .clear (flush),
    .din   (f_din),
    .valid (f_rvalid),
    .dout  (f_dout)
  );

  assign {f_inst1_addr, f_inst2_addr, f_inst1, f_inst2} = f_dout;

  arb_resp_buf #(
    .W (DW)
  ) u_d_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (d_gnt),
    .drain (d_rready),
    .clear (1'b0),
    .din   (rom_inst1),
    .valid (d_rvalid),
    .dout  (d_rdata)
  );

`ifdef INST_ROM_ARB_PERF_EN
  // Free-running wrapping event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_f_gnt    <= '0;
      perf_d_gnt    <= '0;
      perf_conflict <= '0;
    end else begin
      if (f_gnt) begin
        perf_f_gnt <= perf_f_gnt + 32'd1;
      end
      if (d_gnt) begin
        perf_d_gnt <= perf_d_gnt + 32'd1;
      end
      if (f_elig && d_elig) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb/tb_inst_rom_arbiter.sv - randomized and directed checks of inst_rom_arbiter against a behavioural model
module tb_inst_rom_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, f_req, f_rready, flush, d_req, d_rready;
  logic [AW-1:0] f_addr, d_addr;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, rom_ce;
  logic [DW-1:0] f_inst1, f_inst2, d_rdata, rom_inst1, rom_inst2;
  logic [AW-1:0] f_inst1_addr, f_inst2_addr, rom_addr, rom_inst1_addr, rom_inst2_addr;
`ifdef INST_ROM_ARB_PERF_EN
  logic [31:0]   perf_f_gnt, perf_d_gnt, perf_conflict;
`endif

  inst_rom_arbiter #(.STARVE_MAX(SM), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rready(f_rready),
    .f_inst1(f_inst1), .f_inst2(f_inst2), .f_inst1_addr(f_inst1_addr), .f_inst2_addr(f_inst2_addr),
    .flush(flush),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_rready(d_rready),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst1(rom_inst1), .rom_inst2(rom_inst2),
    .rom_inst1_addr(rom_inst1_addr), .rom_inst2_addr(rom_inst2_addr)
`ifdef INST_ROM_ARB_PERF_EN
    , .perf_f_gnt(perf_f_gnt), .perf_d_gnt(perf_d_gnt), .perf_conflict(perf_conflict)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ {a[15:0], a[31:16]};
  endfunction

  always_comb begin
    rom_inst1_addr = rom_addr;
    rom_inst2_addr = rom_addr + 32'd4;
    rom_inst1      = rom_word(rom_addr);
    rom_inst2      = rom_word(rom_addr + 32'd4);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what each requester is currently holding and how often F has lost
  bit          m_fv, m_dv;
  logic [31:0] m_f1, m_f2, m_f1a, m_f2a, m_dd;
  int          m_lost;

  logic        obs_f_gnt, obs_d_gnt;
  logic [31:0] obs_rom_addr;

  task automatic model_reset();
    m_fv = 0; m_dv = 0; m_lost = 0;
    m_f1 = '0; m_f2 = '0; m_f1a = '0; m_f2a = '0; m_dd = '0;
  endtask

  task automatic cycle();
    bit fe, de, fw, dw;
    #3;
    fe = f_req && !flush && (!m_fv || f_rready);
    de = d_req && (!m_dv || d_rready);
    if (fe && de) begin
      fw = (m_lost >= SM);
      dw = !fw;
    end else begin
      fw = fe;
      dw = de;
    end
    if (!rst) begin
      fw = 0;
      dw = 0;
    end
    check("f_gnt", 64'(f_gnt), 64'(fw));
    check("d_gnt", 64'(d_gnt), 64'(dw));
    check("rom_ce", 64'(rom_ce), 64'(fw | dw));
    if (fw) check("rom_addr_f", 64'(rom_addr), 64'(f_addr));
    if (dw) check("rom_addr_d", 64'(rom_addr), 64'(d_addr & ~32'h3));
    check("f_rvalid", 64'(f_rvalid), 64'(m_fv));
    check("d_rvalid", 64'(d_rvalid), 64'(m_dv));
    check("f_inst1", 64'(f_inst1), 64'(m_f1));
    check("f_inst2", 64'(f_inst2), 64'(m_f2));
    check("f_inst1_addr", 64'(f_inst1_addr), 64'(m_f1a));
    check("f_inst2_addr", 64'(f_inst2_addr), 64'(m_f2a));
    check("d_rdata", 64'(d_rdata), 64'(m_dd));
    obs_f_gnt    = f_gnt;
    obs_d_gnt    = d_gnt;
    obs_rom_addr = rom_addr;
    if (!rst) begin
      model_reset();
    end else begin
      if (fw) begin
        m_f1a = f_addr;
        m_f2a = f_addr + 32'd4;
        m_f1  = rom_word(f_addr);
        m_f2  = rom_word(f_addr + 32'd4);
        m_fv  = 1;
      end else if (flush || (m_fv && f_rready)) begin
        m_fv = 0;
      end
      if (dw) begin
        m_dd = rom_word(d_addr & ~32'h3);
        m_dv = 1;
      end else if (m_dv && d_rready) begin
        m_dv = 0;
      end
      if (fe && dw) m_lost = (m_lost < SM) ? m_lost + 1 : SM;
      else m_lost = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit fq, input logic [31:0] fa, input bit frr,
                       input bit fl, input bit dq, input logic [31:0] da, input bit drr);
    rst = r; f_req = fq; f_addr = fa; f_rready = frr;
    flush = fl; d_req = dq; d_addr = da; d_rready = drr;
    cycle();
  endtask

  logic [31:0] held;

  initial begin
    model_reset();
    rst = 0; f_req = 0; f_addr = '0; f_rready = 0; flush = 0; d_req = 0; d_addr = '0; d_rready = 0;
    @(posedge clk);
    #1;

    // reset: requests present but nothing granted
    drive(0, 1, 32'h0, 1, 0, 1, 32'h4, 1);
    check("rst_no_gnt", 64'(obs_f_gnt | obs_d_gnt), 64'(0));
    drive(0, 1, 32'h0, 1, 0, 1, 32'h4, 1);

    // fetch only, streaming
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'(i * 8), 1, 0, 0, 32'h0, 1);
      check("fonly_gnt", 64'(obs_f_gnt), 64'(1));
    end
    drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 1);
    check("fonly_last_addr", 64'(f_inst1_addr), 64'(32'h10));

    // both continuously requesting: D,D,D,D,F
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 32'(i * 8), 1, 0, 1, 32'(i * 4 + 32'h400), 1);
      check("starve_pattern", 64'(obs_f_gnt), 64'((i % 5) == 4));
    end
    drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 1);

    // D backpressure: F gets every cycle
    drive(1, 0, 32'h0, 1, 0, 1, 32'h40, 0);
    held = rom_word(32'h40);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'(32'h80 + i * 8), 1, 0, 1, 32'h44, 0);
      check("bp_d_gnt", 64'(obs_d_gnt), 64'(0));
      check("bp_f_gnt", 64'(obs_f_gnt), 64'(1));
      check("bp_d_rdata", 64'(d_rdata), 64'(held));
    end
    drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 1);

    // flush with a buffered fetch response and a concurrent D request
    drive(1, 1, 32'h100, 0, 0, 0, 32'h0, 1);
    drive(1, 1, 32'h108, 0, 1, 1, 32'h20, 1);
    check("flush_f_gnt", 64'(obs_f_gnt), 64'(0));
    check("flush_d_gnt", 64'(obs_d_gnt), 64'(1));
    check("flush_f_rvalid", 64'(f_rvalid), 64'(0));
    check("flush_d_rdata", 64'(d_rdata), 64'(rom_word(32'h20)));

    // unaligned D address
    drive(1, 0, 32'h0, 1, 0, 1, 32'h13, 1);
    check("unaligned_rom_addr", 64'(obs_rom_addr), 64'(32'h10));
    check("unaligned_d_rdata", 64'(d_rdata), 64'(rom_word(32'h10)));

    // reset with both buffers full
    drive(1, 1, 32'h200, 0, 0, 0, 32'h0, 1);
    drive(1, 0, 32'h0, 0, 0, 1, 32'h30, 0);
    check("full_before_rst", 64'({f_rvalid, d_rvalid}), 64'(2'b11));
    drive(0, 1, 32'h0, 0, 0, 1, 32'h0, 0);
    check("rst_clears_valid", 64'({f_rvalid, d_rvalid}), 64'(2'b00));
`ifdef INST_ROM_ARB_PERF_EN
    check("perf_zero", 64'({perf_f_gnt | perf_d_gnt | perf_conflict}), 64'(0));
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) != 0),
            32'($urandom_range(0, 255)) << 3,
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 6),
            32'($urandom_range(0, 1023)),
            ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
